// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick link, used by the joy_db15 reader
// and by the joy_db15_tx device-side emulator.
package joy_db15_pkg;

   localparam int FRAME_BITS = 24;
   localparam int BTN_BITS   = 12;

   // Button word bit indices, {S,L,F,E,D,C,B,A,U,D,L,R}; BTN_S goes first on the wire
   localparam int BTN_R  = 0;
   localparam int BTN_LF = 1;
   localparam int BTN_DN = 2;
   localparam int BTN_UP = 3;
   localparam int BTN_A  = 4;
   localparam int BTN_B  = 5;
   localparam int BTN_C  = 6;
   localparam int BTN_D  = 7;
   localparam int BTN_E  = 8;
   localparam int BTN_F  = 9;
   localparam int BTN_L  = 10;
   localparam int BTN_S  = 11;

   localparam logic WIRE_ACTIVE = 1'b0;
   localparam logic WIRE_IDLE   = ~WIRE_ACTIVE;

   function automatic logic [2*BTN_BITS-1:0] to_wire(input logic [BTN_BITS-1:0] p1,
                                                      input logic [BTN_BITS-1:0] p2);
      return WIRE_ACTIVE ? {p1, p2} : ~{p1, p2};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous host strobe plus an edge-detect flop.
module sync_edge #(
   parameter logic PRESET = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= PRESET;
         sync_q <= PRESET;
         prev_q <= PRESET;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter emulator: loads two button words on JOY_LOAD low and
// shifts them out MSB-first on JOY_DATA, one bit per JOY_CLK rising edge.
module joy_db15_tx #(
   parameter int FRAME_BITS   = joy_db15_pkg::FRAME_BITS,
   parameter int IDLE_TIMEOUT = 1 << 20
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [11:0] joystick1,
   input  logic [11:0] joystick2,
   input  logic        JOY_LOAD,
   input  logic        JOY_CLK,
   output logic        JOY_DATA,
   output logic        frame_done,
   output logic        overrun,
   output logic        link_idle
);

   import joy_db15_pkg::*;

   localparam int CNT_W  = $clog2(FRAME_BITS + 2);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

   logic                  ld_lvl, ld_rise, ld_fall;
   logic                  clk_lvl, clk_rise, clk_fall;
   logic [FRAME_BITS-1:0] sr;
   logic [CNT_W-1:0]      bit_cnt;
   logic [IDLE_W-1:0]     idle_cnt;
   logic                  unused_edges;

   sync_edge #(.PRESET(1'b1)) u_load_sync (
      .clk      (CLK),
      .rst      (RESET),
      .async_in (JOY_LOAD),
      .level    (ld_lvl),
      .rise     (ld_rise),
      .fall     (ld_fall)
   );

   sync_edge #(.PRESET(1'b1)) u_clk_sync (
      .clk      (CLK),
      .rst      (RESET),
      .async_in (JOY_CLK),
      .level    (clk_lvl),
      .rise     (clk_rise),
      .fall     (clk_fall)
   );

   assign unused_edges = &{1'b0, ld_rise, clk_lvl, clk_fall};

   // Load level has priority, so a shift edge seen while load is low is dropped
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sr         <= '1;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!ld_lvl) begin
            sr      <= to_wire(joystick1, joystick2);
            bit_cnt <= '0;
            overrun <= 1'b0;
         end else if (clk_rise) begin
            sr <= {sr[FRAME_BITS-2:0], WIRE_IDLE};
            if (bit_cnt != CNT_SAT)
               bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_LAST)
               frame_done <= 1'b1;
            if (bit_cnt >= CNT_FULL)
               overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         idle_cnt <= '0;
      else if (ld_fall)
         idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
         idle_cnt <= idle_cnt + IDLE_W'(1);
   end

   assign link_idle = (idle_cnt >= IDLE_MAX);
   assign JOY_DATA  = sr[FRAME_BITS-1];

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: table of full frames plus hand-written
// mid-frame change, overrun, reset and idle-watchdog sequences.
module tb_joy_db15_tx;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [11:0] joystick1, joystick2;
   logic        JOY_LOAD, JOY_CLK;
   logic        JOY_DATA, frame_done, overrun, link_idle;

   int total = 0;
   int bad   = 0;
   int fd_total = 0;

   typedef struct {
      logic [11:0] j1;
      logic [11:0] j2;
      logic [23:0] exp_wire;   // bit 23 = first bit on the wire
   } vec_t;

   vec_t vecs [6];

   joy_db15_tx #(.FRAME_BITS(24), .IDLE_TIMEOUT(100)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .joystick1  (joystick1),
      .joystick2  (joystick2),
      .JOY_LOAD   (JOY_LOAD),
      .JOY_CLK    (JOY_CLK),
      .JOY_DATA   (JOY_DATA),
      .frame_done (frame_done),
      .overrun    (overrun),
      .link_idle  (link_idle)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (frame_done === 1'b1) fd_total++;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish want finish before 2ms");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic host_load();
      JOY_LOAD = 1'b0;
      tick(6);
      JOY_LOAD = 1'b1;
      tick(6);
   endtask

   task automatic host_edge();
      JOY_CLK = 1'b1;
      tick(6);
      JOY_CLK = 1'b0;
      tick(6);
   endtask

   // Reads bits 0..23 and then issues the 24th edge that completes the frame
   task automatic read_frame(output logic [23:0] w);
      w[23] = JOY_DATA;
      for (int i = 1; i < 24; i++) begin
         host_edge();
         w[23-i] = JOY_DATA;
      end
      host_edge();
   endtask

   initial begin
      logic [23:0] w;
      int fd0;
      int n;

      vecs[0] = '{12'h001, 12'h000, 24'hFFEFFF};
      vecs[1] = '{12'hFFF, 12'hA5A, 24'h0005A5};
      vecs[2] = '{12'h000, 12'h000, 24'hFFFFFF};
      vecs[3] = '{12'h800, 12'h001, 24'h7FFFFE};
      vecs[4] = '{12'h5A5, 12'hFFF, 24'hA5A000};
      vecs[5] = '{12'h123, 12'h456, 24'hEDCBA9};

      RESET = 1'b1;
      JOY_LOAD = 1'b1;
      JOY_CLK = 1'b0;
      joystick1 = 12'h000;
      joystick2 = 12'h000;
      tick(3);
      check("rst_data", JOY_DATA, 1);
      check("rst_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_idle", link_idle, 0);
      RESET = 1'b0;
      tick(4);

      for (int v = 0; v < 6; v++) begin
         joystick1 = vecs[v].j1;
         joystick2 = vecs[v].j2;
         fd0 = fd_total;
         host_load();
         check("vec_overrun_clear", overrun, 0);
         read_frame(w);
         check("vec_frame", w, vecs[v].exp_wire);
         check("vec_done_once", fd_total - fd0, 1);
      end

      // Inputs change after 5 shifts: frame in flight keeps the loaded word
      joystick1 = 12'h000;
      joystick2 = 12'h000;
      host_load();
      w[23] = JOY_DATA;
      for (int i = 1; i < 24; i++) begin
         host_edge();
         if (i == 5) joystick1 = 12'h800;
         w[23-i] = JOY_DATA;
      end
      host_edge();
      check("mid_change_frame", w, 24'hFFFFFF);
      host_load();
      read_frame(w);
      check("mid_change_next", w, 24'h7FFFFF);
      check("mid_change_bit0", w[23], 0);

      // 26 edges after one load
      joystick1 = 12'hFFF;
      joystick2 = 12'hA5A;
      host_load();
      read_frame(w);
      check("ovr_frame", w, 24'h0005A5);
      check("ovr_not_yet", overrun, 0);
      host_edge();
      check("ovr_edge25_data", JOY_DATA, 1);
      check("ovr_edge25_flag", overrun, 1);
      host_edge();
      check("ovr_edge26_data", JOY_DATA, 1);
      check("ovr_edge26_flag", overrun, 1);
      host_load();
      check("ovr_cleared", overrun, 0);

      // Reset after 10 shifts
      joystick1 = 12'hFFF;
      joystick2 = 12'hFFF;
      host_load();
      for (int i = 0; i < 10; i++) host_edge();
      check("rstmid_before", JOY_DATA, 0);
      RESET = 1'b1;
      #1;
      check("rstmid_data", JOY_DATA, 1);
      check("rstmid_cnt", dut.bit_cnt, 0);
      @(negedge CLK);
      RESET = 1'b0;
      tick(4);
      joystick1 = 12'h321;
      joystick2 = 12'h000;
      fd0 = fd_total;
      host_load();
      read_frame(w);
      check("rstmid_next_frame", w, 24'hCDEFFF);
      check("rstmid_next_done", fd_total - fd0, 1);

      // Idle watchdog with IDLE_TIMEOUT = 100
      RESET = 1'b1;
      tick(2);
      RESET = 1'b0;
      repeat (99) @(posedge CLK);
      @(negedge CLK);
      check("idle_at_99", link_idle, 0);
      @(posedge CLK);
      @(negedge CLK);
      check("idle_at_100", link_idle, 1);
      tick(20);
      check("idle_at_120", link_idle, 1);
      JOY_LOAD = 1'b0;
      n = 0;
      while (link_idle && n < 10) begin
         @(negedge CLK);
         n++;
      end
      check("idle_fall_within_4", (n <= 4) && !link_idle, 1);
      tick(4);
      JOY_LOAD = 1'b1;
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Device-side emulator of the DB15 serial joystick adapter: it answers the host's JOY_LOAD/JOY_CLK strobes by shifting two players' button words out on JOY_DATA, bit-for-bit compatible with the `joy_db15` reader in our cores. It is used as the bus-functional responder in core testbenches. It is also used in the bridge build, where a USB or keyboard source drives a DB15-expecting core over the UserIO pins. All logic runs in one system clock domain; the strobes from the host are treated as asynchronous and synchronized internally.

## Interface
Parameters:
- FRAME_BITS, 24 — bits per frame (12 per player); must be 24 in product builds.
- IDLE_TIMEOUT, 2^20 — CLK cycles without a load before `link_idle` asserts.

Ports:
- CLK  in  1  system clock, 40–50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- joystick1  in  12  player 1 buttons, active-high, bit order {S,L,F,E,D,C,B,A,U,D,L,R}; index 11 is first on the wire.
- joystick2  in  12  player 2 buttons, same bit order.
- JOY_LOAD  in  1  host load strobe, active-low, asynchronous to CLK.
- JOY_CLK  in  1  host shift clock, asynchronous to CLK.
- JOY_DATA  out  1  serial data, active-low buttons, idles high.
- frame_done  out  1  one-cycle pulse when the final bit of a frame has been shifted past.
- overrun  out  1  sticky flag; set when more than FRAME_BITS shifts occur between loads; cleared by the next load.
- link_idle  out  1  high when no load falling edge has been seen for IDLE_TIMEOUT cycles.

## Operation
- JOY_LOAD and JOY_CLK each pass through a 2-flop synchronizer. A third flop on each provides edge detection.
- Load phase (synchronized load is low):
  - The shift register sr[23:0] is reloaded every cycle with ~{joystick1, joystick2}.
  - The bit counter is cleared and `overrun` is cleared.
  - JOY_DATA = sr[23], which is the inverted player 1 S bit.
- Shift phase (synchronized load is high): on each synchronized JOY_CLK rising edge:
  - sr <= {sr[22:0], 1'b1}.
  - The counter increments, saturating at FRAME_BITS+1.
- The counter reaching FRAME_BITS−1 means the last bit is now presented. The edge that takes the counter to FRAME_BITS pulses `frame_done`. Any further edge sets `overrun`.
- When sr is exhausted, JOY_DATA is 1.
- Input words are sampled only during the load phase. Changes during shifting do not affect the frame in flight.
- Idle watchdog:
  - A counter counts up each cycle and is cleared on every synchronized load falling edge.
  - `link_idle` = (counter ≥ IDLE_TIMEOUT).
  - The counter saturates at IDLE_TIMEOUT.
- Simultaneous JOY_CLK edge and load low: load wins and the edge is ignored.

## Timing
- Reset values:
  - JOY_DATA = 1.
  - sr = all ones.
  - counter = 0.
  - `frame_done`, `overrun`, `link_idle` = 0.
  - Synchronizer flops are preset to 1.
- Latency from a host pin change to JOY_DATA update is 3 CLK cycles (2 sync + 1 register).
- Host requirements:
  - JOY_LOAD low for ≥ 4 CLK cycles.
  - Each JOY_CLK high phase and each low phase ≥ 4 CLK cycles.
  - The host samples JOY_DATA no earlier than 4 CLK cycles after its own JOY_CLK rising edge.
  - Shorter pulses are not guaranteed to be seen.
- `frame_done` is exactly 1 CLK wide, issued in the cycle after the 24th edge is detected.
- If RESET asserts mid-frame, all state returns to reset values immediately. The first frame after release starts at the next load.

## Structure
- A shared package holds:
  - the bit-index constants for the 12-bit button word (BTN_R=0 … BTN_S=11);
  - FRAME_BITS;
  - the active-low wire polarity constant.
  The `joy_db15` reader uses the same package.
- One sub-module, `sync_edge`, is natural. It contains the 2-flop synchronizer plus the edge flop, exposes level, rise and fall outputs, and takes a preset value parameter. It is instantiated twice.

## Test plan
- Player 1 = 12'h001 (R), player 2 = 0; one load, then 24 clocks. Required:
  - JOY_DATA reads 1 for bits 0–10, 0 at bit 11, and 1 for bits 12–23;
  - `frame_done` pulses once.
- Player 1 = 12'hFFF, player 2 = 12'hA5A; full frame. Required:
  - bits 0–11 read 0;
  - bits 12–23 read ~12'hA5A MSB-first (0,1,0,1,1,0,1,0,0,1,0,1).
- Change player 1 from 0 to 12'h800 mid-frame after 5 shifts. Required: the current frame continues unchanged, and the next frame shows bit 0 = 0.
- 26 clock edges after one load. Required:
  - JOY_DATA = 1 for edges 25–26;
  - `overrun` = 1;
  - the next load clears `overrun`.
- Assert RESET after 10 shifts. Required: JOY_DATA = 1 and counter = 0 immediately; the following load and frame are correct.
- With IDLE_TIMEOUT = 100, give no load for 120 cycles. Required: `link_idle` rises at cycle 100, and falls within 4 cycles of the next load falling edge.
